// File: rtl/fmul_arb_pkg.sv
// Shared definitions for the fmul sharing arbiter: FSM encodings and widths.
// Used by fmul_share_arbiter and rr_arbiter.
package fmul_arb_pkg;

  localparam int FP_W    = 32;
  localparam int STATS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or above ptr
// (wrapping past N-1) wins; grant is one-hot, grant_idx is its index.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  int               w_sum;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_sum     = 0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = int'(ptr) + k;
      if (w_sum >= N) begin
        w_sum = w_sum - N;
      end
      w_idx = IDX_W'(w_sum);
      if (!w_found && req[w_idx]) begin
        w_found        = 1'b1;
        grant[w_idx]   = 1'b1;
        grant_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/fmul_share_arbiter.sv
// Shares one external combinational fmul among NUM_REQ requesters, one op in flight.
// Optional per-requester completion counters: define FMUL_SHARE_ARBITER_STATS_EN.
module fmul_share_arbiter
  import fmul_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [FP_W-1:0]         rsp_result,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP_W-1:0]         fmul_a,
  output logic [FP_W-1:0]         fmul_b,
  input  logic [FP_W-1:0]         fmul_result,
  output logic                    busy
`ifdef FMUL_SHARE_ARBITER_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [STATS_W*NUM_REQ-1:0] op_count
`endif
);

  state_t            r_state;
  state_t            w_state_next;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_owner;
  logic [FP_W-1:0]   r_fmul_a;
  logic [FP_W-1:0]   r_fmul_b;
  logic [FP_W-1:0]   r_rsp_result;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_any_req;
  logic               w_accept;
  logic               w_rsp_hs;
  logic [ID_W-1:0]    w_ptr_next;
  logic [FP_W-1:0]    w_sel_a;
  logic [FP_W-1:0]    w_sel_b;
  logic [FP_W-1:0]    w_a_arr [NUM_REQ];
  logic [FP_W-1:0]    w_b_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a_arr[gi] = req_a[gi*FP_W +: FP_W];
    assign w_b_arr[gi] = req_b[gi*FP_W +: FP_W];
  end

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_any_req  = |w_grant;
  assign w_accept   = (r_state == ST_IDLE) && w_any_req;
  assign w_rsp_hs   = (r_state == ST_RESP) && rsp_ready[r_owner];
  assign w_sel_a    = w_a_arr[w_grant_idx];
  assign w_sel_b    = w_b_arr[w_grant_idx];
  // Explicit wrap keeps the pointer inside 0..NUM_REQ-1 for non-power-of-2 sizes.
  assign w_ptr_next = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req) w_state_next = ST_EXEC;
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: if (w_rsp_hs) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    case (r_state)
      ST_IDLE: req_ready = w_grant;
      ST_EXEC: busy = 1'b1;
      ST_RESP: begin
        busy               = 1'b1;
        rsp_valid[r_owner] = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fmul_a     <= '0;
      r_fmul_b     <= '0;
      r_owner      <= '0;
      r_rsp_result <= '0;
      r_rr_ptr     <= '0;
    end else begin
      if (w_accept) begin
        r_fmul_a <= w_sel_a;
        r_fmul_b <= w_sel_b;
        r_owner  <= w_grant_idx;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_result <= fmul_result;
      end
      if (w_rsp_hs) begin
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  assign fmul_a     = r_fmul_a;
  assign fmul_b     = r_fmul_b;
  assign rsp_result = r_rsp_result;
  assign rsp_id     = r_owner;

`ifdef FMUL_SHARE_ARBITER_STATS_EN
  logic [STATS_W-1:0] r_op_count [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_op_count[gi] <= '0;
      end else if (stats_clr) begin
        r_op_count[gi] <= '0;
      end else if (w_rsp_hs && (r_owner == ID_W'(gi))) begin
        r_op_count[gi] <= r_op_count[gi] + 1'b1;
      end
    end
    assign op_count[gi*STATS_W +: STATS_W] = r_op_count[gi];
  end
`endif

endmodule

// File: tb/tb_fmul_share_arbiter.sv
// Directed bench for fmul_share_arbiter with a lookup-table fmul model.
// Define FMUL_SHARE_ARBITER_STATS_EN to also exercise the op counters.
module tb_fmul_share_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [31:0]    rsp_result;
  logic [1:0]     rsp_id;
  logic [31:0]    fmul_a;
  logic [31:0]    fmul_b;
  logic [31:0]    fmul_result;
  logic           busy;
`ifdef FMUL_SHARE_ARBITER_STATS_EN
  logic           stats_clr;
  logic [16*N-1:0] op_count;
  logic           clr_on_hs;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fmul_share_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_id      (rsp_id),
    .fmul_a      (fmul_a),
    .fmul_b      (fmul_b),
    .fmul_result (fmul_result),
    .busy        (busy)
`ifdef FMUL_SHARE_ARBITER_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .op_count    (op_count)
`endif
  );

  // Hand-computed IEEE-754 products for the operand pairs used below.
  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40000000_40400000: return 32'h40C00000; // 2.0 * 3.0 = 6.0
      64'h3FC00000_3FC00000: return 32'h40100000; // 1.5 * 1.5 = 2.25
      64'hC0000000_3F000000: return 32'hBF800000; // -2.0 * 0.5 = -1.0
      64'h3F800000_40A00000: return 32'h40A00000; // 1.0 * 5.0 = 5.0
      64'h40000000_40000000: return 32'h40800000; // 2.0 * 2.0 = 4.0
      64'h40400000_40400000: return 32'h41100000; // 3.0 * 3.0 = 9.0
      default:               return a ^ b;
    endcase
  endfunction

  always_comb fmul_result = fmul_model(fmul_a, fmul_b);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_valid[id]      = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge in IDLE with requester id's operands already presented.
  task automatic run_op(input int id, input logic [31:0] exp_res);
    logic [31:0] one_hot;
    one_hot = 32'd1 << id;
    #1;
    check_eq("grant", req_ready, one_hot);
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
    check_eq("exec_busy", busy, 32'd1);
    check_eq("exec_ready", req_ready, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("rsp_valid", rsp_valid, one_hot);
    check_eq("rsp_result", rsp_result, exp_res);
    check_eq("rsp_id", rsp_id, id);
`ifdef FMUL_SHARE_ARBITER_STATS_EN
    stats_clr = clr_on_hs;
`endif
    @(posedge clk);
    @(negedge clk);
`ifdef FMUL_SHARE_ARBITER_STATS_EN
    stats_clr = 1'b0;
`endif
    check_eq("done_busy", busy, 32'd0);
    check_eq("done_rsp_valid", rsp_valid, 32'd0);
    $display("op req=%0d result=%h", id, rsp_result);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;
`ifdef FMUL_SHARE_ARBITER_STATS_EN
    stats_clr = 1'b0;
    clr_on_hs = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_req_ready", req_ready, 32'd0);
    check_eq("rst_rsp_valid", rsp_valid, 32'd0);
    check_eq("rst_fmul_a", fmul_a, 32'd0);
    check_eq("rst_fmul_b", fmul_b, 32'd0);
    check_eq("rst_rsp_result", rsp_result, 32'd0);
    check_eq("rst_rsp_id", rsp_id, 32'd0);
    rst_n = 1'b1;

    // Single request, 2.0 * 3.0.
    set_req(0, 32'h40000000, 32'h40400000);
    run_op(0, 32'h40C00000);

    // All four valid from reset: grants 0,1,2,3.
    apply_reset();
    set_req(0, 32'h3F800000, 32'h40A00000);
    set_req(1, 32'h40000000, 32'h40000000);
    set_req(2, 32'h3FC00000, 32'h3FC00000);
    set_req(3, 32'h40400000, 32'h40400000);
    run_op(0, 32'h40A00000);
    run_op(1, 32'h40800000);
    run_op(2, 32'h40100000);
    run_op(3, 32'h41100000);

    // Response backpressure on requester 1 while 0 and 3 wait.
    set_req(1, 32'hC0000000, 32'h3F000000);
    rsp_ready = '0;
    #1;
    check_eq("bp_grant", req_ready, 32'h2);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    set_req(0, 32'h3F800000, 32'h40A00000);
    set_req(3, 32'h40400000, 32'h40400000);
    #1;
    check_eq("bp_exec_ready", req_ready, 32'd0);
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check_eq("bp_rsp_valid", rsp_valid, 32'h2);
      check_eq("bp_rsp_result", rsp_result, 32'hBF800000);
      check_eq("bp_rsp_id", rsp_id, 32'd1);
      check_eq("bp_req_ready", req_ready, 32'd0);
      check_eq("bp_fmul_a", fmul_a, 32'hC0000000);
      rsp_ready[0] = (c == 1);
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("bp_still_valid", rsp_valid, 32'h2);
    rsp_ready = '1;
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_released", busy, 32'd0);
    $display("op req=1 result=%h", rsp_result);
    // Pointer now 2: requester 3 before 0.
    run_op(3, 32'h41100000);
    run_op(0, 32'h40A00000);

    // Wrap: after serving 3, requesters 3 and 1 -> 1 first.
    set_req(3, 32'h40400000, 32'h40400000);
    run_op(3, 32'h41100000);
    set_req(3, 32'h40400000, 32'h40400000);
    set_req(1, 32'h40000000, 32'h40000000);
    run_op(1, 32'h40800000);
    run_op(3, 32'h41100000);

    // Move pointer to 2, then reset during EXEC of requester 2.
    set_req(1, 32'h40000000, 32'h40000000);
    run_op(1, 32'h40800000);
    set_req(2, 32'h3FC00000, 32'h3FC00000);
    #1;
    check_eq("rx_grant", req_ready, 32'h4);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    check_eq("rx_exec_busy", busy, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rx_busy", busy, 32'd0);
    check_eq("rx_fmul_a", fmul_a, 32'd0);
    check_eq("rx_fmul_b", fmul_b, 32'd0);
    check_eq("rx_rsp_result", rsp_result, 32'd0);
    check_eq("rx_rsp_id", rsp_id, 32'd0);
    check_eq("rx_rsp_valid", rsp_valid, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rx_no_rsp", rsp_valid, 32'd0);
      check_eq("rx_idle", busy, 32'd0);
    end
    // Pointer back at 0: requester 1 wins over 3.
    set_req(1, 32'h40000000, 32'h40000000);
    set_req(3, 32'h40400000, 32'h40400000);
    run_op(1, 32'h40800000);
    run_op(3, 32'h41100000);

`ifdef FMUL_SHARE_ARBITER_STATS_EN
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      set_req(2, 32'h3FC00000, 32'h3FC00000);
      run_op(2, 32'h40100000);
    end
    check_eq("stats_cnt2", op_count[32 +: 16], 32'd3);
    check_eq("stats_cnt0", op_count[0 +: 16], 32'd0);
    clr_on_hs = 1'b1;
    set_req(2, 32'h3FC00000, 32'h3FC00000);
    run_op(2, 32'h40100000);
    clr_on_hs = 1'b0;
    check_eq("stats_clr", op_count[32 +: 16], 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fmul_share_arbiter.md
Name: fmul_share_arbiter

Overview:
- Shares one combinational single-precision multiplier (fmul) between NUM_REQ requesters, e.g. the multi-cycle core's FP execute stage plus auxiliary units.
- Round-robin arbitration, per-requester valid/ready request and response handshakes.
- Operand and result registers around the shared datapath; one operation in flight at a time.
- The multiplier is instantiated outside this block and connected through the fmul_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of owner index; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  32*NUM_REQ  operand A; slice i belongs to requester i.
- req_b  input  32*NUM_REQ  operand B, same slicing.
- rsp_valid  output  NUM_REQ  result valid; one-hot or zero, owner only.
- rsp_ready  input  NUM_REQ  per-requester result accept.
- rsp_result  output  32  registered product, shared by all requesters.
- rsp_id  output  ID_W  owner index of current response.
- fmul_a  output  32  registered operand A to shared multiplier.
- fmul_b  output  32  registered operand B to shared multiplier.
- fmul_result  input  32  product from shared multiplier, combinational from fmul_a/fmul_b.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; rr_ptr=0.
  - fmul_a, fmul_b, rsp_result and owner are all 0.
  - req_ready, rsp_valid and busy are 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Round-robin pick among req_valid, starting at rr_ptr and searching upward with wrap.
  - req_ready[winner]=1 combinationally in the same cycle; the handshake completes that cycle.
  - On the edge: latch req_a/req_b slices into fmul_a/fmul_b, owner=winner, go to EXEC.
  - No valid requests: stay in IDLE; rr_ptr unchanged; req_ready all 0.
- EXEC (1 cycle):
  - The shared fmul settles.
  - On the edge: rsp_result<=fmul_result; go to RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_id=owner.
  - Hold rsp_result, rsp_id and fmul_a/fmul_b stable until rsp_ready[owner]=1.
  - On the handshake: rr_ptr=(owner+1) mod NUM_REQ; go to IDLE.
  - rsp_ready of non-owners is ignored.
- Latency and throughput:
  - Request accepted at edge T; rsp_valid high from T+2.
  - Minimum of 3 cycles per operation.
  - No request/response overlap: req_ready is 0 outside IDLE.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 operations.
- rr_ptr wraps from NUM_REQ-1 to 0. With NUM_REQ not a power of 2, pointer values >= NUM_REQ never occur.
- req_valid may drop in any cycle before its grant without side effects. Requesters must hold their operands while req_valid is high.
- Arithmetic: the block does not inspect operands. Product values, including zero/denormal/inf inputs, are whatever fmul produces.
- Reset mid-operation: the in-flight operation is discarded and no response is issued.
- Same-cycle response and request: no overlap. The response handshake in RESP occurs one cycle before the next grant in IDLE.

Optional Feature:
- Macro FMUL_SHARE_ARBITER_STATS_EN.
- Defined:
  - Adds output op_count, 16*NUM_REQ bits: per-requester counters of completed response handshakes.
  - Counters wrap at 0xFFFF and reset to 0.
  - Adds input stats_clr (1 bit), a synchronous clear of all counters. stats_clr wins over a same-cycle increment.
- Undefined: ports, counters and clear logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fmul_arb_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2;
  - FP_W=32;
  - the counter width STATS_W=16.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs grant one-hot and grant_idx. Purely combinational.
- The FSM, registers and stats counters stay in the top module.

Test Plan:
- Single request: req 0 with a=0x40000000 (2.0), b=0x40400000 (3.0); rsp_ready held high -> rsp_valid[0] at T+2, rsp_result=0x40C00000, rsp_id=0, busy low at T+3.
- All four requesters valid at once from reset:
  - grants in order 0,1,2,3;
  - requester 2 with a=b=0x3FC00000 (1.5) returns 0x40100000.
- Response backpressure:
  - requester 1 sends a=0xC0000000 (-2.0), b=0x3F000000 (0.5) and holds rsp_ready low for 5 cycles -> rsp_valid[1] and rsp_result=0xBF800000 held stable;
  - req_ready stays 0 for pending requesters 0 and 3;
  - requester 0 pulses rsp_ready during this time with no effect.
- Round-robin wrap: after serving requester 3, requesters 3 and 1 both valid -> requester 1 granted before 3.
- Async reset asserted during EXEC -> all outputs 0 immediately; no rsp_valid after release; the next request is served normally with rr_ptr=0.
- With FMUL_SHARE_ARBITER_STATS_EN: 3 ops on requester 2 -> op_count slice 2 = 3; stats_clr in the same cycle as a 4th completion -> 0.
